// File: rtl/router_reg_if.sv
// router_reg_if: byte datapath, FIFO status, controller state strobes and
// registered outputs that connect the router controller side to router_reg.
interface router_reg_if #(
    parameter int DATA_W = 8
);
    logic              pkt_valid;
    logic [DATA_W-1:0] datain;
    logic              fifo_full;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic [DATA_W-1:0] dout;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              err;

    modport master (
        output pkt_valid, datain, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  pkt_valid, datain, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );
endinterface

// File: rtl/router_reg.sv
// router_reg: packet datapath register of the router. Captures the header,
// forwards payload bytes to the FIFO write port, parks a byte in a holding
// register while the FIFO is full, and tracks packet parity.
// Optional macro ROUTER_REG_PARITY_CHK_EN compiles in the internal parity,
// packet parity and err logic; without it err is tied low.
module router_reg #(
    parameter int DATA_W = 8
) (
    input logic       clk,
    input logic       rst,
    router_reg_if.slave bus
);

    logic [DATA_W-1:0] header_q, header_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              parity_done_q, parity_done_d;
    logic              low_pkt_valid_q, low_pkt_valid_d;

    // A valid header carrying address 2'b11 freezes every register.
    logic illegal_hdr;
    // One-hot strobes resolved by priority: detect_add, lfd, ld, laf.
    logic det_s, lfd_s, ld_s, laf_s;

    assign illegal_hdr = bus.detect_add && bus.pkt_valid && (bus.datain[1:0] == 2'b11);
    assign det_s = bus.detect_add;
    assign lfd_s = bus.lfd_state && !bus.detect_add;
    assign ld_s  = bus.ld_state && !bus.detect_add && !bus.lfd_state;
    assign laf_s = bus.laf_state && !bus.detect_add && !bus.lfd_state && !bus.ld_state;

    // Next-state for header, holding, output byte and status flags.
    always_comb begin
        header_d        = header_q;
        hold_d          = hold_q;
        dout_d          = dout_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        if (!illegal_hdr) begin
            if (det_s && bus.pkt_valid) begin
                header_d = bus.datain;
            end
            if (lfd_s) begin
                dout_d = header_q;
            end else if (ld_s) begin
                if (!bus.fifo_full) begin
                    dout_d = bus.datain;
                end else begin
                    hold_d = bus.datain;
                end
            end else if (laf_s) begin
                dout_d = hold_q;
            end
            if (det_s) begin
                parity_done_d = 1'b0;
            end else if (ld_s && !bus.pkt_valid && !bus.fifo_full) begin
                parity_done_d = 1'b1;
            end else if (laf_s && low_pkt_valid_q && !parity_done_q) begin
                parity_done_d = 1'b1;
            end
            if (bus.rst_int_reg) begin
                low_pkt_valid_d = 1'b0;
            end else if (ld_s && !bus.pkt_valid) begin
                low_pkt_valid_d = 1'b1;
            end
        end
    end

    // Datapath and status registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            header_q        <= '0;
            hold_q          <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_q        <= header_d;
            hold_q          <= hold_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;

`ifdef ROUTER_REG_PARITY_CHK_EN
    logic [DATA_W-1:0] int_parity_q, int_parity_d;
    logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
    logic              err_q, err_d;

    // Running XOR of header and payload, received parity byte and compare.
    always_comb begin
        int_parity_d = int_parity_q;
        pkt_parity_d = pkt_parity_q;
        err_d        = err_q;
        if (!illegal_hdr) begin
            if (det_s) begin
                int_parity_d = '0;
            end else if (lfd_s) begin
                int_parity_d = int_parity_q ^ header_q;
            end else if (ld_s && bus.pkt_valid && !bus.fifo_full && !bus.full_state) begin
                int_parity_d = int_parity_q ^ bus.datain;
            end
            if (ld_s && !bus.pkt_valid && !bus.fifo_full) begin
                pkt_parity_d = bus.datain;
            end
            if (det_s) begin
                err_d = 1'b0;
            end else if (parity_done_q) begin
                err_d = (int_parity_q != pkt_parity_q);
            end
        end
    end

    // Parity registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_parity_q <= '0;
            pkt_parity_q <= '0;
            err_q        <= 1'b0;
        end else begin
            int_parity_q <= int_parity_d;
            pkt_parity_q <= pkt_parity_d;
            err_q        <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_full_state;
    assign unused_full_state = bus.full_state;
    assign bus.err           = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: scoreboard bench for router_reg. Each driven cycle pushes the
// expected registered outputs; they are popped and compared one cycle later.
// err expectations apply only when ROUTER_REG_PARITY_CHK_EN is defined.
module tb_router_reg;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_DET  = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b000100;
    localparam logic [5:0] S_FULL = 6'b000010;
    localparam logic [5:0] S_RINT = 6'b000001;

    typedef struct {
        string      tag;
        logic [7:0] dout;
        logic       pd;
        logic       lpv;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;
    exp_t exp_q[$];

    router_reg_if #(.DATA_W(8)) bus ();

    router_reg #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".dout"}, 32'(bus.dout), 32'h0);
        checkOutput({tag, ".pd"},   32'(bus.parity_done), 32'h0);
        checkOutput({tag, ".lpv"},  32'(bus.low_pkt_valid), 32'h0);
        checkOutput({tag, ".err"},  32'(bus.err), 32'h0);
    endtask

    task automatic applyStimulus(input string tag, input logic [5:0] strb, input logic pv,
                                 input logic [7:0] din, input logic ff, input logic [7:0] e_dout,
                                 input logic e_pd, input logic e_lpv, input logic e_err);
        exp_t e;
        {bus.detect_add, bus.lfd_state, bus.ld_state,
         bus.laf_state, bus.full_state, bus.rst_int_reg} = strb;
        bus.pkt_valid = pv;
        bus.datain    = din;
        bus.fifo_full = ff;
        e.tag  = tag;
        e.dout = e_dout;
        e.pd   = e_pd;
        e.lpv  = e_lpv;
`ifdef ROUTER_REG_PARITY_CHK_EN
        e.err  = e_err;
`else
        e.err  = 1'b0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput({e.tag, ".dout"}, 32'(bus.dout), 32'(e.dout));
        checkOutput({e.tag, ".pd"},   32'(bus.parity_done), 32'(e.pd));
        checkOutput({e.tag, ".lpv"},  32'(bus.low_pkt_valid), 32'(e.lpv));
        checkOutput({e.tag, ".err"},  32'(bus.err), 32'(e.err));
    endtask

    // Directed packet sequences with hand-derived expectations.
    initial begin
        check_count = 0;
        pass_count  = 0;
        rst = 1'b0;
        {bus.detect_add, bus.lfd_state, bus.ld_state,
         bus.laf_state, bus.full_state, bus.rst_int_reg} = S_NONE;
        bus.pkt_valid = 1'b0;
        bus.datain    = 8'h00;
        bus.fifo_full = 1'b0;
        #2;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Good packet
        applyStimulus("good.det",  S_DET,  1'b1, 8'h0D, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("good.lfd",  S_LFD,  1'b1, 8'h11, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("good.d11",  S_LD,   1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus("good.d22",  S_LD,   1'b1, 8'h22, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus("good.d33",  S_LD,   1'b1, 8'h33, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus("good.par",  S_LD,   1'b0, 8'h0D, 1'b0, 8'h0D, 1'b1, 1'b1, 1'b0);
        applyStimulus("good.chk",  S_NONE, 1'b0, 8'h00, 1'b0, 8'h0D, 1'b1, 1'b1, 1'b0);
        applyStimulus("good.rint", S_RINT, 1'b0, 8'h00, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b0);

        // Bad parity byte
        applyStimulus("bad.det",   S_DET,  1'b1, 8'h0D, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("bad.lfd",   S_LFD,  1'b1, 8'h11, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("bad.d11",   S_LD,   1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus("bad.d22",   S_LD,   1'b1, 8'h22, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus("bad.d33",   S_LD,   1'b1, 8'h33, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus("bad.par",   S_LD,   1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);
        applyStimulus("bad.chk",   S_NONE, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
        applyStimulus("bad.rint",  S_RINT, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
        applyStimulus("bad.clr",   S_DET,  1'b1, 8'h0D, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

        // FIFO full on byte 22; the source re-presents it after the stall
        applyStimulus("full.det",  S_DET,  1'b1, 8'h0D, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.lfd",  S_LFD,  1'b1, 8'h11, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.d11",  S_LD,   1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.d22f", S_LD,   1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.fst",  S_FULL, 1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.laf",  S_LAF,  1'b1, 8'h22, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.d22",  S_LD,   1'b1, 8'h22, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.d33",  S_LD,   1'b1, 8'h33, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus("full.par",  S_LD,   1'b0, 8'h0D, 1'b0, 8'h0D, 1'b1, 1'b1, 1'b0);
        applyStimulus("full.chk",  S_NONE, 1'b0, 8'h00, 1'b0, 8'h0D, 1'b1, 1'b1, 1'b0);
        applyStimulus("full.rint", S_RINT, 1'b0, 8'h00, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b0);

        // Early pkt_valid drop while the FIFO is full; laf completes parity_done
        applyStimulus("low.det",   S_DET,  1'b1, 8'h0D, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("low.lfd",   S_LFD,  1'b1, 8'h11, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("low.d11",   S_LD,   1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus("low.drop",  S_LD,   1'b0, 8'h1C, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        applyStimulus("low.fst",   S_FULL, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        applyStimulus("low.laf",   S_LAF,  1'b0, 8'h00, 1'b0, 8'h1C, 1'b1, 1'b1, 1'b0);
        applyStimulus("low.rint",  S_RINT, 1'b0, 8'h00, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b1);

        // Illegal address header leaves the stored header alone
        applyStimulus("ill.det0D", S_DET,  1'b1, 8'h0D, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus("ill.det07", S_DET,  1'b1, 8'h07, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus("ill.lfd",   S_LFD,  1'b1, 8'h11, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);

        // Async reset between clock edges mid-packet
        applyStimulus("ar.det",    S_DET,  1'b1, 8'h0D, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("ar.lfd",    S_LFD,  1'b1, 8'h11, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        applyStimulus("ar.d11",    S_LD,   1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus("ar.d55",    S_LD,   1'b0, 8'h55, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0);
        applyStimulus("ar.chk",    S_NONE, 1'b0, 8'h00, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1);
        bus.ld_state  = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.datain    = 8'h22;
        #3;
        rst = 1'b0;
        #1;
        checkAllZero("ar.async");
        @(posedge clk);
        #1;
        checkAllZero("ar.held");
        rst = 1'b1;
        applyStimulus("ar.lfd0",   S_LFD,  1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("ar.det2",   S_DET,  1'b1, 8'h0D, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("ar.lfd2",   S_LFD,  1'b1, 8'h11, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 Parameter DATA_W, default 8, byte width of the packet datapath; DATA_W SHALL be at least 3.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 pkt_valid  input  1  source byte-valid; deasserts with the parity byte.
REQ-005 datain  input  DATA_W  source byte; header bits [1:0] hold the destination address.
REQ-006 fifo_full  input  1  full flag of the currently addressed output FIFO.
REQ-007 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  input  1 each  one-hot state strobes from the router controller FSM.
REQ-008 dout  output  DATA_W  registered byte to the FIFO write port.
REQ-009 parity_done  output  1  packet parity byte has been captured.
REQ-010 low_pkt_valid  output  1  pkt_valid fell while the block was loading.
REQ-011 err  output  1  computed parity differs from received parity.

Function
REQ-012 All outputs SHALL be registered, with one-clock latency from the qualifying strobe.
REQ-013 Header register: load datain when detect_add=1, pkt_valid=1 and datain[1:0]!=2'b11; otherwise hold its value.
REQ-014 dout priority:
- detect_add: hold.
- lfd_state: load the header register.
- ld_state with fifo_full=0: load datain.
- ld_state with fifo_full=1: hold dout and load datain into the holding register.
- laf_state: load the holding register.
- All other cases: hold.
REQ-015 Internal parity:
- Clear on detect_add.
- XOR with the header register on lfd_state.
- XOR with datain on ld_state when pkt_valid=1, fifo_full=0 and full_state=0.
- Hold otherwise.
REQ-016 Packet-parity register: load datain on ld_state when pkt_valid=0 and fifo_full=0.
REQ-017 parity_done:
- Clear on detect_add, which has priority.
- Set on ld_state when pkt_valid=0 and fifo_full=0.
- Set on laf_state when low_pkt_valid=1 and parity_done=0.
- Hold otherwise.
REQ-018 low_pkt_valid: clear on rst_int_reg, which has priority; set on ld_state when pkt_valid=0; hold otherwise.
REQ-019 err: clear on detect_add; when parity_done=1, load (internal parity != packet parity); hold otherwise. err SHALL be valid one cycle after parity_done rises.
REQ-020 Simultaneous strobes are illegal input; if they occur, detect_add SHALL win, then lfd_state, ld_state, laf_state.
REQ-021 A header with address 2'b11 SHALL leave every register unchanged.

Reset
REQ-022 When rst=0, the block SHALL immediately clear dout, parity_done, low_pkt_valid and err, and clear the header, holding, internal-parity and packet-parity registers, without waiting for clk.
REQ-023 Reset mid-packet SHALL abandon the packet; the next packet SHALL start clean from detect_add.

Configuration
REQ-024 Macro ROUTER_REG_PARITY_CHK_EN.
- Defined: the internal-parity, packet-parity and err logic SHALL be compiled in as specified above.
- Undefined: that logic SHALL be removed, err SHALL be constant 0, and parity_done and dout SHALL behave identically to the defined case.

Verification
REQ-025 Good packet: header 8'h0D, payload 8'h11, 8'h22, 8'h33, parity 8'h0D, no FIFO full -> dout = 0D, 11, 22, 33, 0D; parity_done=1 one cycle after the parity byte; err=0 one cycle later.
REQ-026 Bad parity: same packet with parity byte 8'hFF -> err=1 one cycle after parity_done; err clears on the next detect_add.
REQ-027 FIFO full: fifo_full=1 during ld_state while datain=8'h22, then full_state, then laf_state -> dout holds 8'h11 through full_state, then dout=8'h22 after laf_state; parity still matches, err=0.
REQ-028 Early pkt_valid drop: pkt_valid=0 in ld_state -> low_pkt_valid=1 next cycle; a following rst_int_reg pulse -> low_pkt_valid=0.
REQ-029 Illegal address: detect_add with datain=8'h07 after a prior header 8'h0D -> the header register stays 8'h0D; a later lfd_state drives dout=8'h0D.
REQ-030 Async reset: assert rst=0 mid-payload, between clock edges -> all outputs 0 before the next clk edge, and they stay 0 until rst=1.
